// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_rr_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one port of a 16x16
//            dual-port RAM among up to NREQ requesters. Each grant performs
//            one read or write. The result is returned with a one-cycle ack.
// Options  : ARB_FIXED_PRIO0_EN - requester 0 always wins when requesting;
//            the others rotate among themselves.
// Revision : 1.0 - initial release
// ============================================================================
module ram_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    req_we_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [DW-1:0]      rdata_o,
    output logic [NREQ-1:0]    grant_o,
    output logic               busy_o,
    output logic               ram_en_o,
    output logic               ram_we_o,
    output logic [AW-1:0]      ram_addr_o,
    output logic [DW-1:0]      ram_din_o,
    input  logic [DW-1:0]      ram_dout_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef ARB_FIXED_PRIO0_EN
    localparam bit FIXED0 = 1'b1;
`else
    localparam bit FIXED0 = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic               we_q, we_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               ram_en_q, ram_en_d;
    logic               ram_we_q, ram_we_d;
    logic [AW-1:0]      ram_addr_q, ram_addr_d;
    logic [DW-1:0]      ram_din_q, ram_din_d;

    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic               win_upd;
    logic [IW-1:0]      cand_idx;

    // Winner search: first requester after the last owner, wrapping around.
    // With fixed priority, requester 0 pre-empts and leaves the pointer alone.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_upd   = 1'b1;
        cand_idx  = '0;
        if (FIXED0 && req_i[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
            win_upd   = 1'b0;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                cand_idx = IW'((int'(last_q) + k) % NREQ);
                if (!win_found && req_i[cand_idx] && !(FIXED0 && cand_idx == '0)) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        we_d       = we_q;
        grant_d    = grant_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = ACCESS;
                    grant_d    = NREQ'(1) << win_idx;
                    if (win_upd) begin
                        last_d = win_idx;
                    end
                    // The RAM port registers double as the request latches.
                    we_d       = req_we_i[win_idx];
                    ram_en_d   = 1'b1;
                    ram_we_d   = req_we_i[win_idx];
                    ram_addr_d = req_addr_i[int'(win_idx)*AW +: AW];
                    ram_din_d  = req_wdata_i[int'(win_idx)*DW +: DW];
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                    ack_d   = grant_q;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rdata_d = ram_dout_i;
                ack_d   = grant_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            last_q     <= IW'(NREQ - 1);
            we_q       <= 1'b0;
            grant_q    <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            we_q       <= we_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

    assign ack_o      = ack_q;
    assign rdata_o    = rdata_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != IDLE);
    assign ram_en_o   = ram_en_q;
    assign ram_we_o   = ram_we_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_din_o  = ram_din_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_rr_arbiter
// Purpose  : Self-checking bench for ram_rr_arbiter with a RAM model and a
//            transaction-timeline reference model.
// Options  : ARB_FIXED_PRIO0_EN selects the fixed-priority expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_rr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 4;
    localparam int DW   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req, req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    ack, grant;
    logic [DW-1:0]      rdata;
    logic               busy, ram_en, ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_din;
    logic [DW-1:0]      ram_dout = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .ack_o       (ack),
        .rdata_o     (rdata),
        .grant_o     (grant),
        .busy_o      (busy),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_din_o   (ram_din),
        .ram_dout_i  (ram_dout)
    );

    // RAM port with registered read data
    logic [DW-1:0] ram [16];
    initial for (int i = 0; i < 16; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_din;
            else        ram_dout      <= ram[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: a transaction occupies a fixed window of cycles after
    // its grant edge (2 for write, 3 for read); everything follows from that.
    bit            m_valid = 0;
    bit            m_act   = 0;
    bit            m_we    = 0;
    int            m_t0    = 0;
    int            m_len   = 0;
    int            m_idx   = 0;
    int            m_last  = NREQ - 1;
    int            cyc     = 0;
    int            w, d;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] ref_mem [16];
    initial for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef ARB_FIXED_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (last + k) % NREQ;
`ifdef ARB_FIXED_PRIO0_EN
            if (j == 0) continue;
`endif
            if (r[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (m_act && m_we && cyc - m_t0 == 1) ref_mem[m_addr] = m_wdata;
        if (!rst_n) begin
            m_valid = 1;
            m_act   = 0;
            m_last  = NREQ - 1;
            m_rdata = '0;
            m_addr  = '0;
            m_wdata = '0;
        end else if (m_act) begin
            if (!m_we && cyc - m_t0 == 2) m_rdata = ref_mem[m_addr];
            if (cyc - m_t0 == m_len) m_act = 0;
        end else begin
            w = pick(req, m_last);
            if (w >= 0) begin
                m_act   = 1;
                m_t0    = cyc;
                m_idx   = w;
                m_we    = req_we[w];
                m_addr  = req_addr[w*AW +: AW];
                m_wdata = req_wdata[w*DW +: DW];
                m_len   = m_we ? 2 : 3;
`ifdef ARB_FIXED_PRIO0_EN
                if (w != 0) m_last = w;
`else
                m_last = w;
`endif
            end
        end
        #2;
        if (m_valid) begin
            d = cyc - m_t0;
            chk("m_grant", grant,    m_act ? 32'(1 << m_idx) : 32'd0);
            chk("m_ack",   ack,      (m_act && d == m_len - 1) ? 32'(1 << m_idx) : 32'd0);
            chk("m_busy",  busy,     32'(m_act));
            chk("m_en",    ram_en,   32'(m_act && d == 0));
            chk("m_we",    ram_we,   32'(m_act && d == 0 && m_we));
            chk("m_addr",  ram_addr, 32'(m_addr));
            chk("m_din",   ram_din,  32'(m_wdata));
            chk("m_rdata", rdata,    32'(m_rdata));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    // Record indices of the next n grants (rising edges of grant).
    task automatic record_grants(input int n, output int seq [8], output int ng);
        logic [NREQ-1:0] prev;
        prev = grant;
        ng = 0;
        for (int i = 0; i < 8; i++) seq[i] = -1;
        for (int c = 0; c < 60 && ng < n; c++) begin
            @(negedge clk);
            if (grant != 0 && prev == 0) begin
                seq[ng] = $clog2(grant);
                ng++;
            end
            prev = grant;
        end
    endtask

    int seq [8];
    int ng;

    initial begin
        rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", ram_en, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write from requester 1
        req[1] = 1'b1; req_we[1] = 1'b1; req_addr[1*AW +: AW] = 4'h3; req_wdata[1*DW +: DW] = 16'hA5A5;
        @(negedge clk);
        chk("w_en", ram_en, 1);
        chk("w_we", ram_we, 1);
        chk("w_addr", ram_addr, 4'h3);
        chk("w_din", ram_din, 16'hA5A5);
        chk("w_grant", grant, 4'b0010);
        @(negedge clk);
        chk("w_ack", ack, 4'b0010);
        chk("w_en_off", ram_en, 0);
        req = '0;
        @(negedge clk);
        chk("w_idle", busy, 0);

        // Read back from requester 2
        req[2] = 1'b1; req_we[2] = 1'b0; req_addr[2*AW +: AW] = 4'h3;
        @(negedge clk);
        chk("r_en", ram_en, 1);
        chk("r_we", ram_we, 0);
        chk("r_busy1", busy, 1);
        @(negedge clk);
        chk("r_en_off", ram_en, 0);
        chk("r_busy2", busy, 1);
        @(negedge clk);
        chk("r_ack", ack, 4'b0100);
        chk("r_rdata", rdata, 16'hA5A5);
        chk("r_busy3", busy, 1);
        req = '0;
        @(negedge clk);
        chk("r_hold", rdata, 16'hA5A5);

        // Contention: everyone writes its index to its own address
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = AW'(i);
            req_wdata[i*DW +: DW] = DW'(i);
        end
        req_we = '1;
        req    = '1;
        record_grants(5, seq, ng);
        req = '0;
        wait_idle();
        chk("c_count", ng, 5);
`ifdef ARB_FIXED_PRIO0_EN
        for (int i = 0; i < 5; i++) chk("c_order", seq[i], 0);
`else
        chk("c_order0", seq[0], 0);
        chk("c_order1", seq[1], 1);
        chk("c_order2", seq[2], 2);
        chk("c_order3", seq[3], 3);
        chk("c_order4", seq[4], 0);
        for (int i = 0; i < 4; i++) chk("c_mem", ram[i], i);
`endif

        // Mid-transaction changes are ignored
        @(negedge clk);
        req[1] = 1'b1; req_we[1] = 1'b1; req_addr[1*AW +: AW] = 4'h5; req_wdata[1*DW +: DW] = 16'h1234;
        @(negedge clk);
        chk("m_addr5", ram_addr, 4'h5);
        req_addr[1*AW +: AW] = 4'h9; req_wdata[1*DW +: DW] = 16'hFFFF; req = '0;
        @(negedge clk);
        chk("m_ack1", ack, 4'b0010);
        wait_idle();
        chk("m_mem5", ram[5], 16'h1234);
        chk("m_mem9", ram[9], 16'h0000);

        // Reset during CAPTURE of a read
        @(negedge clk);
        req[3] = 1'b1; req_we[3] = 1'b0; req_addr[3*AW +: AW] = 4'h5;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; req = '0;
        @(negedge clk);
        chk("x_ack", ack, 0);
        chk("x_grant", grant, 0);
        chk("x_busy", busy, 0);
        chk("x_en", ram_en, 0);
        chk("x_rdata", rdata, 0);
        chk("x_addr", ram_addr, 0);
        chk("x_din", ram_din, 0);
        rst_n = 1'b1;
        req = 4'b1001; req_we = '0;
        @(negedge clk);
        chk("x_first", grant, 4'b0001);
        req = '0;
        wait_idle();

`ifdef ARB_FIXED_PRIO0_EN
        // Fixed priority: 0 dominates; 1 and 3 alternate without it
        @(negedge clk);
        req_we = '1;
        req = 4'b1001;
        record_grants(4, seq, ng);
        req = '0;
        wait_idle();
        chk("f_count0", ng, 4);
        for (int i = 0; i < 4; i++) chk("f_zero", seq[i], 0);
        @(negedge clk);
        req = 4'b1010;
        record_grants(4, seq, ng);
        req = '0;
        wait_idle();
        chk("f_count1", ng, 4);
        chk("f_alt0", seq[0], 1);
        chk("f_alt1", seq[1], 3);
        chk("f_alt2", seq[2], 1);
        chk("f_alt3", seq[3], 3);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
